// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers, sitting beside EX.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix-up at the end.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state  | meaning
   // IDLE   | waiting for start or an MTHI/MTLO move
   // MUL    | one shift-add iteration per cycle
   // DIV    | one restoring quotient bit per cycle, MSB first
   // FIX    | sign correction, HI/LO write, done pulse
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   localparam int CW = $clog2(WIDTH);

   state_t             state, state_nxt;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0]   opb, opb_nxt;
   logic [CW-1:0]      count, count_nxt;
   logic               neg_prod, neg_prod_nxt;
   logic               neg_quo, neg_quo_nxt;
   logic               neg_rem, neg_rem_nxt;
   logic [WIDTH-1:0]   hi_nxt, lo_nxt;
   logic               busy_nxt, done_nxt;

   logic               signed_op;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_part, div_diff;
   logic [2*WIDTH-1:0] res_fix;
   logic               last_iter;

   always_comb begin
      signed_op = ~op[0];
      mag_a     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
      mag_b     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;
      // acc = {running high half, multiplier bits still to consume}
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
      div_part  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_part - {1'b0, opb};
      last_iter = (count == CW'(WIDTH-1));
      res_fix   = acc;
      if (neg_prod) begin
         res_fix = -acc;
      end else begin
         if (neg_quo) res_fix[WIDTH-1:0]       = -acc[WIDTH-1:0];
         if (neg_rem) res_fix[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      state_nxt    = state;
      acc_nxt      = acc;
      opb_nxt      = opb;
      count_nxt    = count;
      neg_prod_nxt = neg_prod;
      neg_quo_nxt  = neg_quo;
      neg_rem_nxt  = neg_rem;
      hi_nxt       = hi;
      lo_nxt       = lo;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      case (state)
         S_IDLE: begin
            if (!cancel) begin
               if (start) begin
                  busy_nxt     = 1'b1;
                  count_nxt    = '0;
                  neg_prod_nxt = 1'b0;
                  neg_quo_nxt  = 1'b0;
                  neg_rem_nxt  = 1'b0;
                  if (!op[1]) begin
                     state_nxt    = S_MUL;
                     opb_nxt      = mag_a;
                     acc_nxt      = {{WIDTH{1'b0}}, mag_b};
                     neg_prod_nxt = signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  end else if (src_b == '0) begin
                     state_nxt = S_FIX;
                     opb_nxt   = '0;
                     acc_nxt   = {src_a, {WIDTH{1'b1}}};
                  end else begin
                     state_nxt   = S_DIV;
                     opb_nxt     = mag_b;
                     acc_nxt     = {{WIDTH{1'b0}}, mag_a};
                     neg_quo_nxt = signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                     neg_rem_nxt = signed_op & src_a[WIDTH-1];
                  end
               end else begin
                  if (mthi) hi_nxt = src_a;
                  if (mtlo) lo_nxt = src_a;
               end
            end
         end
         S_MUL: begin
            if (cancel) begin
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
            end else begin
               acc_nxt   = {mul_sum, acc[WIDTH-1:1]};
               count_nxt = count + CW'(1);
               if (last_iter) state_nxt = S_FIX;
            end
         end
         S_DIV: begin
            if (cancel) begin
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
            end else begin
               if (!div_diff[WIDTH])
                  acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else
                  acc_nxt = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               count_nxt = count + CW'(1);
               if (last_iter) state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
            if (!cancel) begin
               hi_nxt   = res_fix[2*WIDTH-1:WIDTH];
               lo_nxt   = res_fix[WIDTH-1:0];
               done_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= S_IDLE;
         acc      <= '0;
         opb      <= '0;
         count    <= '0;
         neg_prod <= 1'b0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         opb      <= opb_nxt;
         count    <= count_nxt;
         neg_prod <= neg_prod_nxt;
         neg_quo  <= neg_quo_nxt;
         neg_rem  <= neg_rem_nxt;
         hi       <= hi_nxt;
         lo       <= lo_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level HI/LO model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic        cancel = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .nrst(nrst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .mthi(mthi), .mtlo(mtlo), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of one operation: {HI, LO}
   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (o)
         2'd0: p = sa * sb;
         2'd1: p = {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_done = 1'b0;
   int          m_left = 0;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_left != 0) begin
            if (cancel) m_left <= 0;
            else begin
               m_left <= m_left - 1;
               if (m_left == 1) begin
                  m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
               end
            end
         end else if (!cancel) begin
            if (start) begin
               {p_hi, p_lo} <= ref_op(op, src_a, src_b);
               m_left <= (op[1] && src_b == 0) ? 1 : 33;
            end else begin
               if (mthi) m_hi <= src_a;
               if (mtlo) m_lo <= src_a;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model busy", {63'd0, busy}, {63'd0, m_left != 0});
         chk("model done", {63'd0, done}, {63'd0, m_done});
         chk("model hi", {32'd0, hi}, {32'd0, m_hi});
         chk("model lo", {32'd0, lo}, {32'd0, m_lo});
      end
   end

   task automatic drive(input logic st, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic mh, input logic ml, input logic cn);
      @(posedge clk); #2;
      start = st; op = o; src_a = a; src_b = b; mthi = mh; mtlo = ml; cancel = cn;
      @(posedge clk); #2;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0; cancel = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      cyc = 0; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
         if (busy) cyc++;
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic mh, input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_cyc);
      int cyc; bit ok;
      drive(1'b1, o, a, b, mh, 1'b0, 1'b0);
      wait_done(cyc, ok);
      chk({name, " done seen"}, {63'd0, ok}, 64'd1);
      chk({name, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
      chk({name, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
      chk({name, " busy cycles"}, 64'(cyc), 64'(exp_cyc));
      chk({name, " busy at done"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int cyc, ndone;
      bit ok;
      #11;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset hi", {32'd0, hi}, 64'd0);
      chk("reset lo", {32'd0, lo}, 64'd0);
      nrst = 1'b1;
      chk_en = 1'b1;

      run_op("MULT -1*7", 2'd0, 32'hFFFF_FFFF, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 33);
      run_op("MULTU max*max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 33);
      run_op("DIV -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      run_op("DIVU 100/7", 2'd3, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 33);
      run_op("DIV ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 33);
      run_op("DIVU by 0", 2'd3, 32'h0000_1234, 32'd0, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
      run_op("DIV 7/-3", 2'd2, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'd1, 32'hFFFF_FFFE, 33);
      run_op("MULT -3*-5", 2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, 32'd0, 32'd15, 33);
      // start beats a same-cycle move
      run_op("DIVU start+mthi", 2'd3, 32'd50, 32'd5, 1'b1, 32'd0, 32'd10, 33);

      // new start in the cycle done is high
      drive(1'b1, 2'd1, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
      wait_done(cyc, ok);
      start = 1'b1; op = 2'd3; src_a = 32'd9; src_b = 32'd4;
      @(posedge clk); #2;
      start = 1'b0;
      wait_done(cyc, ok);
      chk("b2b done seen", {63'd0, ok}, 64'd1);
      chk("b2b lo", {32'd0, lo}, 64'd2);
      chk("b2b hi", {32'd0, hi}, 64'd1);

      // start and moves during busy are ignored
      drive(1'b1, 2'd1, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 2'd3, 32'd100, 32'd0, 1'b1, 1'b1, 1'b0);
      wait_done(cyc, ok);
      chk("busy-ignore hi", {32'd0, hi}, 64'd0);
      chk("busy-ignore lo", {32'd0, lo}, 64'd42);

      // cancel in IDLE suppresses start and moves
      drive(1'b1, 2'd1, 32'd9, 32'd9, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("idle cancel busy", {63'd0, busy}, 64'd0);
      chk("idle cancel lo", {32'd0, lo}, 64'd42);

      drive(1'b0, 2'd0, 32'h1357_9BDF, 32'd0, 1'b1, 1'b1, 1'b0);
      chk("mthi+mtlo hi", {32'd0, hi}, 64'h1357_9BDF);
      chk("mthi+mtlo lo", {32'd0, lo}, 64'h1357_9BDF);

      drive(1'b0, 2'd0, 32'hA5A5_A5A5, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("mthi hi", {32'd0, hi}, 64'hA5A5_A5A5);

      // cancel at iteration 10 of MULT 3*3
      drive(1'b1, 2'd0, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #2 cancel = 1'b1;
      @(posedge clk); #2 cancel = 1'b0;
      @(negedge clk);
      chk("cancel busy", {63'd0, busy}, 64'd0);
      chk("cancel hi", {32'd0, hi}, 64'hA5A5_A5A5);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("cancel no done", 64'(ndone), 64'd0);

      // async reset at iteration 20 of a DIV
      drive(1'b1, 2'd2, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
      repeat (19) @(posedge clk);
      #2 nrst = 1'b0;
      #1;
      chk("mid reset busy", {63'd0, busy}, 64'd0);
      chk("mid reset done", {63'd0, done}, 64'd0);
      chk("mid reset hi", {32'd0, hi}, 64'd0);
      chk("mid reset lo", {32'd0, lo}, 64'd0);
      @(negedge clk); #1 nrst = 1'b1;
      drive(1'b0, 2'd0, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("mtlo after reset lo", {32'd0, lo}, 64'd5);
      chk("mtlo after reset hi", {32'd0, hi}, 64'd0);
      repeat (40) @(negedge clk);
      chk("no stray busy", {63'd0, busy}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, attached beside the EX stage of the five-stage forwarding pipeline. EX issues MULT/MULTU/DIV/DIVU operands, already resolved through the forwarding muxes, with a one-cycle `start`. The unit then runs a radix-2 shift-add or restoring-divide sequence and raises `busy`. Hazard detection uses `busy` to stall any later MFHI/MFLO/MTHI/MTLO or mult/div instruction until `done`.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; fixed at 32 for this core.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- start  in  1  accept a new operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- src_a  in  32  rs value: multiplicand or dividend; also the MTHI/MTLO data.
- src_b  in  32  rt value: multiplier or divisor.
- mthi  in  1  write `src_a` to HI; honoured only in IDLE.
- mtlo  in  1  write `src_a` to LO; honoured only in IDLE.
- cancel  in  1  squash the in-flight operation (branch/jump flush).
- busy  out  1  registered; high while an operation is in flight.
- done  out  1  registered; one-cycle pulse when HI/LO take a result.
- hi  out  32  HI register (MFHI source).
- lo  out  32  LO register (MFLO source).

## Operation
- Reset (`nrst`=0, async): state IDLE, hi=lo=0, busy=0, done=0, counter=0, internal datapath registers cleared. This applies mid-operation too; no partial result survives.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start, op MULT/MULTU: latch |a|,|b| for signed ops (raw values for unsigned), record result sign = a[31]^b[31] (signed only), counter=0, go to MUL.
- IDLE + start, op DIV/DIVU, src_b≠0: latch magnitudes, record quotient sign a[31]^b[31] and remainder sign a[31] (signed only), go to DIV.
- IDLE + start, DIV/DIVU, src_b==0: go straight to FIX with HI=src_a, LO=32'hFFFF_FFFF; no sign correction.
- MUL: each cycle, a 64-bit accumulator adds the shifted multiplicand when the current multiplier bit is 1; counter++. After the 32nd iteration, go to FIX.
- DIV: restoring division, one quotient bit per cycle, MSB first. The 33-bit trial subtract keeps the difference when it is non-negative. After 32 iterations, go to FIX.
- FIX: apply two's-complement negation per recorded signs (64-bit for the product; quotient and remainder separately). Write HI/LO, busy→0, done→1, go to IDLE.
- Result mapping: product[63:32]→HI, product[31:0]→LO; remainder→HI, quotient→LO.
- Overflow case 0x8000_0000 / −1 (DIV): LO=0x8000_0000, HI=0. This falls out of the magnitude datapath with no special case.
- cancel: in MUL/DIV/FIX, go to IDLE next edge with busy→0 and done=0; HI/LO keep their pre-start values. In IDLE, cancel also suppresses a same-cycle start, mthi or mtlo.
- start, mthi or mtlo while busy: ignored; stalling these is the hazard unit's job.
- start and mthi/mtlo in the same IDLE cycle: start wins; the move is dropped.
- mthi and mtlo together: both registers written with src_a.

## Timing
- Edge E0 samples start. busy is high from after E0.
- MUL/DIV iterations occupy E1–E32; FIX is E33.
- After E33: hi/lo hold the result, busy=0, done=1 for exactly one cycle. Total: 33 busy cycles.
- Divide by zero: FIX at E1; result, busy=0 and done=1 after E1.
- A new start is accepted in the same cycle done is high, since the unit is already IDLE.
- mthi/mtlo: HI/LO updated at the next edge; done stays 0.
- hi/lo change only at FIX or on an accepted move; they are stable throughout busy.

## Test plan
- Reset, then MULT src_a=0xFFFF_FFFF, src_b=7 → after E33: hi=0xFFFF_FFFF, lo=0xFFFF_FFF9, done pulses 1 cycle, busy high for 33 cycles.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV −7 (0xFFFF_FFF9) / 2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- DIVU 0x1234/0 → after E1: hi=0x1234, lo=0xFFFF_FFFF, done=1, busy=0.
- mthi src_a=0xA5A5_A5A5 → hi=0xA5A5_A5A5 next edge. Then start MULT 3×3 and assert cancel at iteration 10 → busy=0 next edge, hi still 0xA5A5_A5A5, done never asserts.
- Drop nrst at iteration 20 of a DIV → hi=lo=0, busy=0, done=0 immediately. After release, MTLO 5 → lo=5.
